// File: rtl/dffnrnq_pipe_pkg.sv
// Shared sizing helpers and stage record type for the falling-edge register pipeline.
package dffnrnq_pipe_pkg;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int SCAN_LEN(input int width, input int depth);
    return depth * (width + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_rec_t;

endpackage

// File: rtl/dffnrnq_pipe_stage.sv
// One {valid, data} negative-edge register with async active-low reset and load enable.
// Optional scan mux when DFFNRNQ_PIPE_SCAN_EN is defined.
module dffnrnq_pipe_stage
  import dffnrnq_pipe_pkg::*;
#(
  parameter int           WIDTH   = 8,
  parameter logic [WIDTH:0] RST_VAL = '0
) (
  input  logic           clkn,
  input  logic           rn,
  input  logic           ld,
  input  logic [WIDTH:0] d,
`ifdef DFFNRNQ_PIPE_SCAN_EN
  input  logic           se,
  input  logic           si,
  output logic           so,
`endif
  output logic [WIDTH:0] q
);

  logic [WIDTH:0] rec_q;
  logic [WIDTH:0] rec_d;

  always_comb begin
    rec_d = rec_q;
`ifdef DFFNRNQ_PIPE_SCAN_EN
    // Scan order inside a record is LSB first, valid bit last.
    if (se)      rec_d = {rec_q[WIDTH-1:0], si};
    else if (ld) rec_d = d;
`else
    if (ld) rec_d = d;
`endif
  end

  always_ff @(negedge clkn or negedge rn) begin
    if (!rn) rec_q <= RST_VAL;
    else     rec_q <= rec_d;
  end

  assign q = rec_q;
`ifdef DFFNRNQ_PIPE_SCAN_EN
  assign so = rec_q[WIDTH];
`endif

endmodule

// File: rtl/dffnrnq_pipe.sv
// WIDTH x DEPTH falling-edge delay line with valid tracking, enable, flush and occupancy count.
// Optional scan chain over all stage bits when DFFNRNQ_PIPE_SCAN_EN is defined.
module dffnrnq_pipe
  import dffnrnq_pipe_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               GATE_INVALID = 0
) (
  input  logic                      CLKN,
  input  logic                      RN,
  input  logic [WIDTH-1:0]          D,
  input  logic                      DV,
  input  logic                      EN,
  input  logic                      FLUSH,
`ifdef DFFNRNQ_PIPE_SCAN_EN
  input  logic                      SE,
  input  logic                      SI,
  output logic                      SO,
`endif
  output logic [WIDTH-1:0]          Q,
  output logic                      QV,
  output logic [cnt_w(DEPTH)-1:0]   CNT
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0][WIDTH:0] rec_q;
  logic [DEPTH-1:0][WIDTH:0] rec_d;
  logic [DEPTH-1:0][WIDTH:0] rec_shift;
  logic [DEPTH-1:0]          valid_q;
  logic                      ld;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;

  assign ld = FLUSH | EN;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign rec_shift[gi] = {DV, D};
      end else begin : g_body
        assign rec_shift[gi] = rec_q[gi-1];
      end
      assign valid_q[gi] = rec_q[gi][WIDTH];

      dffnrnq_pipe_stage #(
        .WIDTH  (WIDTH),
        .RST_VAL({1'b0, RESET_VAL})
      ) u_stage (
        .clkn(CLKN),
        .rn  (RN),
        .ld  (ld),
        .d   (rec_d[gi]),
`ifdef DFFNRNQ_PIPE_SCAN_EN
        .se  (SE),
        .si  ((gi == 0) ? SI : rec_q[(gi == 0) ? 0 : gi-1][WIDTH]),
        .so  (),
`endif
        .q   (rec_q[gi])
      );
    end
  endgenerate

  // A flush keeps data in place and only drops the valid bits.
  always_comb begin
    rec_d = rec_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (FLUSH) rec_d[i] = {1'b0, rec_q[i][WIDTH-1:0]};
      else       rec_d[i] = rec_shift[i];
    end
  end

`ifdef DFFNRNQ_PIPE_SCAN_EN
  logic          se_q;
  logic [CW-1:0] pop_next;

  // Occupancy after this edge's load, used to resync the counter after scan.
  always_comb begin
    pop_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld) pop_next = pop_next + CW'(rec_d[i][WIDTH]);
      else    pop_next = pop_next + CW'(valid_q[i]);
    end
  end

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) se_q <= 1'b0;
    else     se_q <= SE;
  end

  assign SO = valid_q[DEPTH-1];
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (FLUSH) begin
      cnt_d = '0;
    end else if (EN) begin
      if (DV && !valid_q[DEPTH-1])      cnt_d = cnt_q + CW'(1);
      else if (!DV && valid_q[DEPTH-1]) cnt_d = cnt_q - CW'(1);
    end
`ifdef DFFNRNQ_PIPE_SCAN_EN
    if (SE)        cnt_d = cnt_q;
    else if (se_q) cnt_d = pop_next;
`endif
  end

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign QV  = valid_q[DEPTH-1];
  assign CNT = cnt_q;

  generate
    if (GATE_INVALID != 0) begin : g_gate
      assign Q = QV ? rec_q[DEPTH-1][WIDTH-1:0] : RESET_VAL;
    end else begin : g_nogate
      assign Q = rec_q[DEPTH-1][WIDTH-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_dffnrnq_pipe.sv
// Directed bench for dffnrnq_pipe: ungated and gated WIDTH=8/DEPTH=3 instances,
// plus a WIDTH=2/DEPTH=1 scan instance when DFFNRNQ_PIPE_SCAN_EN is defined.
module tb_dffnrnq_pipe;

  logic       clkn = 1'b1;
  logic       rn   = 1'b1;
  logic [7:0] d    = '0;
  logic       dv   = 1'b0;
  logic       en   = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] q_a, q_b;
  logic       qv_a, qv_b;
  logic [1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkn = ~clkn;

`ifdef DFFNRNQ_PIPE_SCAN_EN
  logic       se0 = 1'b0, si0 = 1'b0, so_a, so_b;
  logic [1:0] d_s  = '0;
  logic       dv_s = 1'b0, en_s = 1'b0, fl_s = 1'b0, se_s = 1'b0, si_s = 1'b0, so_s;
  logic [1:0] q_s;
  logic       qv_s;
  logic [0:0] cnt_s;

  dffnrnq_pipe #(.WIDTH(2), .DEPTH(1), .RESET_VAL(2'b00), .GATE_INVALID(0)) u_dut_s (
    .CLKN(clkn), .RN(rn), .D(d_s), .DV(dv_s), .EN(en_s), .FLUSH(fl_s),
    .SE(se_s), .SI(si_s), .SO(so_s), .Q(q_s), .QV(qv_s), .CNT(cnt_s));
`endif

  dffnrnq_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .GATE_INVALID(0)) u_dut_a (
    .CLKN(clkn), .RN(rn), .D(d), .DV(dv), .EN(en), .FLUSH(flush),
`ifdef DFFNRNQ_PIPE_SCAN_EN
    .SE(se0), .SI(si0), .SO(so_a),
`endif
    .Q(q_a), .QV(qv_a), .CNT(cnt_a));

  dffnrnq_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .GATE_INVALID(1)) u_dut_b (
    .CLKN(clkn), .RN(rn), .D(d), .DV(dv), .EN(en), .FLUSH(flush),
`ifdef DFFNRNQ_PIPE_SCAN_EN
    .SE(se0), .SI(si0), .SO(so_b),
`endif
    .Q(q_b), .QV(qv_b), .CNT(cnt_b));

  task automatic edge_n();
    @(negedge clkn);
    #1;
  endtask

  task automatic drive(input logic [7:0] dd, input logic vv, input logic ee, input logic ff);
    d = dd; dv = vv; en = ee; flush = ff;
  endtask

  task automatic test_reset();
    #1 rn = 1'b0;
    #1;
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'h00, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL reset_init got q=%h qv=%b cnt=%0d want q=00 qv=0 cnt=0", q_a, qv_a, cnt_a);
    end
    #2 rn = 1'b1;
    drive(8'h77, 1'b1, 1'b1, 1'b0);
    edge_n();
    edge_n();
    n_checks++;
    if (cnt_a !== 2'd2) begin
      n_errors++; $display("FAIL pre_reset_cnt got %0d want 2", cnt_a);
    end
    #1 rn = 1'b0;
    #1;
    $display("reset mid-traffic: q=%h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
    n_checks++;
    if ({q_a, qv_a, cnt_a, q_b, qv_b, cnt_b} !== {8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL async_reset got q=%h qv=%b cnt=%0d want q=00 qv=0 cnt=0", q_a, qv_a, cnt_a);
    end
    #1 rn = 1'b1;
    drive(8'h5A, 1'b1, 1'b1, 1'b0);
    edge_n();
    $display("first edge after reset: q=%h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'h00, 1'b0, 2'd1}) begin
      n_errors++; $display("FAIL post_reset_load got q=%h qv=%b cnt=%0d want q=00 qv=0 cnt=1", q_a, qv_a, cnt_a);
    end
  endtask

  task automatic test_fill();
    drive(8'h11, 1'b1, 1'b1, 1'b0); edge_n();
    drive(8'h22, 1'b1, 1'b1, 1'b0); edge_n();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'h5A, 1'b1, 2'd3}) begin
      n_errors++; $display("FAIL fill_5a got q=%h qv=%b cnt=%0d want q=5a qv=1 cnt=3", q_a, qv_a, cnt_a);
    end
    drive(8'h33, 1'b1, 1'b1, 1'b0); edge_n();
    $display("fill edge3: q=%h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
    n_checks++;
    if ({q_a, qv_a, cnt_a, q_b} !== {8'h11, 1'b1, 2'd3, 8'h11}) begin
      n_errors++; $display("FAIL fill_11 got q=%h qv=%b cnt=%0d qg=%h want q=11 qv=1 cnt=3 qg=11", q_a, qv_a, cnt_a, q_b);
    end
    drive(8'h44, 1'b0, 1'b1, 1'b0); edge_n();
    $display("fill edge4: q=%h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'h22, 1'b1, 2'd2}) begin
      n_errors++; $display("FAIL fill_22 got q=%h qv=%b cnt=%0d want q=22 qv=1 cnt=2", q_a, qv_a, cnt_a);
    end
  endtask

  task automatic test_hold();
    drive(8'hA1, 1'b1, 1'b1, 1'b0); edge_n();
    drive(8'hA2, 1'b1, 1'b1, 1'b0); edge_n();
    drive(8'hA3, 1'b1, 1'b1, 1'b0); edge_n();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'hA1, 1'b1, 2'd3}) begin
      n_errors++; $display("FAIL hold_full got q=%h qv=%b cnt=%0d want q=a1 qv=1 cnt=3", q_a, qv_a, cnt_a);
    end
    drive(8'hFF, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clkn); #1;
      n_checks++;
      if ({q_a, qv_a, cnt_a} !== {8'hA1, 1'b1, 2'd3}) begin
        n_errors++; $display("FAIL hold_rise%0d got q=%h qv=%b cnt=%0d want q=a1 qv=1 cnt=3", k, q_a, qv_a, cnt_a);
      end
      edge_n();
      $display("hold edge%0d: q=%h qv=%b cnt=%0d", k, q_a, qv_a, cnt_a);
      n_checks++;
      if ({q_a, qv_a, cnt_a} !== {8'hA1, 1'b1, 2'd3}) begin
        n_errors++; $display("FAIL hold_fall%0d got q=%h qv=%b cnt=%0d want q=a1 qv=1 cnt=3", k, q_a, qv_a, cnt_a);
      end
    end
  endtask

  task automatic test_flush();
    drive(8'hEE, 1'b1, 1'b1, 1'b1); edge_n();
    $display("flush: q=%h qv=%b cnt=%0d gated=%h", q_a, qv_a, cnt_a, q_b);
    n_checks++;
    if ({q_a, qv_a, cnt_a, q_b} !== {8'hA1, 1'b0, 2'd0, 8'h00}) begin
      n_errors++; $display("FAIL flush got q=%h qv=%b cnt=%0d qg=%h want q=a1 qv=0 cnt=0 qg=00", q_a, qv_a, cnt_a, q_b);
    end
    drive(8'h00, 1'b0, 1'b1, 1'b0); edge_n(); edge_n();
    n_checks++;
    if ({q_a, qv_a, cnt_a} !== {8'hA3, 1'b0, 2'd0}) begin
      n_errors++; $display("FAIL flush_nocapture got q=%h qv=%b cnt=%0d want q=a3 qv=0 cnt=0", q_a, qv_a, cnt_a);
    end
  endtask

  task automatic test_bubbles();
    logic [4:0]  dv_seq;
    logic [39:0] exp_q, exp_g;
    logic [4:0]  exp_qv;
    logic [9:0]  exp_cnt;
    dv_seq  = 5'b10101;
    exp_q   = {8'h03, 8'h02, 8'h01, 8'h00, 8'h00};
    exp_g   = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00};
    exp_qv  = 5'b10100;
    exp_cnt = {2'd2, 2'd1, 2'd2, 2'd1, 2'd1};
    for (int k = 0; k < 5; k++) begin
      drive(8'(k + 1), dv_seq[k], 1'b1, 1'b0);
      edge_n();
      $display("bubble edge%0d: q=%h qv=%b cnt=%0d gated=%h", k + 1, q_a, qv_a, cnt_a, q_b);
      n_checks++;
      if ({q_a, qv_a, cnt_a, q_b} !== {exp_q[k*8 +: 8], exp_qv[k], exp_cnt[k*2 +: 2], exp_g[k*8 +: 8]}) begin
        n_errors++;
        $display("FAIL bubble%0d got q=%h qv=%b cnt=%0d qg=%h want q=%h qv=%b cnt=%0d qg=%h", k + 1,
                 q_a, qv_a, cnt_a, q_b, exp_q[k*8 +: 8], exp_qv[k], exp_cnt[k*2 +: 2], exp_g[k*8 +: 8]);
      end
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef DFFNRNQ_PIPE_SCAN_EN
  task automatic test_scan();
    logic [2:0] si_seq, so_seq;
    si_seq = 3'b101;
    so_seq = 3'b100;
    d_s = 2'b01; dv_s = 1'b0; en_s = 1'b1;
    edge_n();
    en_s = 1'b0; se_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      si_s = si_seq[k];
      #1;
      n_checks++;
      if (so_s !== so_seq[k]) begin
        n_errors++; $display("FAIL scan_so%0d got %b want %b", k, so_s, so_seq[k]);
      end
      edge_n();
      $display("scan shift%0d: si=%b so=%b", k, si_s, so_s);
    end
    n_checks++;
    if ({q_s, qv_s, cnt_s} !== {2'b01, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL scan_state got q=%b qv=%b cnt=%0d want q=01 qv=1 cnt=0", q_s, qv_s, cnt_s);
    end
    se_s = 1'b0;
    edge_n();
    n_checks++;
    if ({q_s, qv_s, cnt_s} !== {2'b01, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL scan_cnt got q=%b qv=%b cnt=%0d want q=01 qv=1 cnt=1", q_s, qv_s, cnt_s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_flush();
    test_bubbles();
`ifdef DFFNRNQ_PIPE_SCAN_EN
    test_scan();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
